// File: rtl/ppm_tx_if.sv
// Wishbone slave bus bundle for the PPM transmitter register file.
interface ppm_tx_if;
  logic        wb_cyc_i;
  logic        wb_stb_i;
  logic        wb_we_i;
  logic [6:0]  wb_adr_i;
  logic [15:0] wb_dat_i;
  logic [15:0] wb_dat_o;
  logic        wb_ack_o;

  modport master (
    output wb_cyc_i, wb_stb_i, wb_we_i, wb_adr_i, wb_dat_i,
    input  wb_dat_o, wb_ack_o
  );

  modport slave (
    input  wb_cyc_i, wb_stb_i, wb_we_i, wb_adr_i, wb_dat_i,
    output wb_dat_o, wb_ack_o
  );
endinterface

// File: rtl/ppm_tx.sv
// PPM pulse-train generator: up to 8 channels, 1 us resolution, Wishbone
// register file with per-frame shadow latching so bus writes never tear a frame.
module ppm_tx #(
  parameter int unsigned CLK_DIV     = 75,
  parameter int unsigned CH_MIN_US   = 800,
  parameter int unsigned CH_MAX_US   = 2200,
  parameter int unsigned MIN_SYNC_US = 4000
) (
  input  logic     wb_clk_i,
  input  logic     wb_rst_i,
  ppm_tx_if.slave  wb,
  output logic     ppm_out,
  output logic     frame_start_o
);

  localparam int unsigned PRESC_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [PRESC_W-1:0] PRESC_LAST = PRESC_W'(CLK_DIV - 1);
  localparam logic [15:0] CH_MIN    = 16'(CH_MIN_US);
  localparam logic [15:0] CH_MAX    = 16'(CH_MAX_US);
  localparam logic [15:0] PW_MAX    = 16'(CH_MIN_US - 1);
  localparam logic [15:0] SYNC_LAST = 16'(MIN_SYNC_US - 1);

  localparam logic [2:0] S_IDLE       = 3'd0;
  localparam logic [2:0] S_PULSE      = 3'd1;
  localparam logic [2:0] S_SPACE      = 3'd2;
  localparam logic [2:0] S_SYNC_PULSE = 3'd3;
  localparam logic [2:0] S_SYNC_SPACE = 3'd4;

  // Live registers
  logic [15:0] ch_q [8];
  logic [15:0] ch_d [8];
  logic [3:0]  ctrl_q, ctrl_d;
  logic [15:0] frame_q, frame_d;
  logic [15:0] pw_q, pw_d;

  // Per-frame shadows
  logic [15:0] ch_sh_q [8];
  logic [15:0] ch_sh_d [8];
  logic [2:0]  nch_sh_q, nch_sh_d;
  logic [15:0] frame_sh_q, frame_sh_d;
  logic [15:0] pw_sh_q, pw_sh_d;

  // Sequencer
  logic [2:0]         state_q, state_d;
  logic [2:0]         chan_q, chan_d;
  logic [15:0]        slot_q, slot_d;
  logic [15:0]        frame_el_q, frame_el_d;
  logic [15:0]        sync_el_q, sync_el_d;
  logic [PRESC_W-1:0] presc_q, presc_d;
  logic [14:0]        fcnt_q, fcnt_d;
  logic               ppm_q, ppm_d;
  logic               fs_q, fs_d;

  logic        bus_sel, bus_wr, is_ch;
  logic [2:0]  ch_idx;
  logic [15:0] rdata;
  logic        tick, busy, start_c;
  logic        pulse_last, space_last, sync_done;
  logic [15:0] space_len;

  function automatic logic [15:0] clamp_ch(input logic [15:0] v);
    if (v < CH_MIN)      return CH_MIN;
    else if (v > CH_MAX) return CH_MAX;
    else                 return v;
  endfunction

  function automatic logic [15:0] clamp_pw(input logic [15:0] v);
    if (v == 16'd0)       return 16'd1;
    else if (v >= CH_MIN) return PW_MAX;
    else                  return v;
  endfunction

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  assign bus_sel = wb.wb_cyc_i & wb.wb_stb_i;
  assign bus_wr  = bus_sel & wb.wb_we_i;
  assign ch_idx  = wb.wb_adr_i[3:1];
  assign is_ch   = (wb.wb_adr_i[6:4] == 3'b110) && !wb.wb_adr_i[0];
  assign busy    = (state_q != S_IDLE);
  assign tick    = (presc_q == PRESC_LAST);

  assign wb.wb_ack_o = bus_sel;
  assign wb.wb_dat_o = rdata;
  assign ppm_out       = ppm_q;
  assign frame_start_o = fs_q;

  // Register writes from the bus (live copies only)
  always_comb begin
    for (int unsigned i = 0; i < 8; i++) ch_d[i] = ch_q[i];
    ctrl_d  = ctrl_q;
    frame_d = frame_q;
    pw_d    = pw_q;
    if (bus_wr) begin
      if (is_ch) begin
        ch_d[ch_idx] = wb.wb_dat_i;
      end else begin
        case (wb.wb_adr_i)
          7'h70:   ctrl_d  = wb.wb_dat_i[3:0];
          7'h72:   frame_d = wb.wb_dat_i;
          7'h74:   pw_d    = wb.wb_dat_i;
          default: ;
        endcase
      end
    end
  end

  // Combinational read mux; unmapped and odd addresses read zero
  always_comb begin
    rdata = '0;
    if (bus_sel) begin
      if (is_ch) begin
        rdata = ch_q[ch_idx];
      end else begin
        case (wb.wb_adr_i)
          7'h70:   rdata = {12'd0, ctrl_q};
          7'h72:   rdata = frame_q;
          7'h74:   rdata = pw_q;
          7'h76:   rdata = {fcnt_q, busy};
          default: rdata = '0;
        endcase
      end
    end
  end

  // Tick prescaler, slot sequencer and frame-start shadow latch
  always_comb begin
    for (int unsigned i = 0; i < 8; i++) ch_sh_d[i] = ch_sh_q[i];
    nch_sh_d   = nch_sh_q;
    frame_sh_d = frame_sh_q;
    pw_sh_d    = pw_sh_q;
    state_d    = state_q;
    chan_d     = chan_q;
    slot_d     = slot_q;
    frame_el_d = frame_el_q;
    sync_el_d  = sync_el_q;
    fcnt_d     = fcnt_q;
    ppm_d      = ppm_q;
    fs_d       = 1'b0;
    start_c    = 1'b0;

    space_len  = ch_sh_q[chan_q] - pw_sh_q;
    pulse_last = (slot_q == pw_sh_q - 16'd1);
    space_last = (slot_q == space_len - 16'd1);
    sync_done  = (({1'b0, frame_el_q} + 17'd1) >= {1'b0, frame_sh_q}) &&
                 (sync_el_q >= SYNC_LAST);

    // Idle prescaler rests at 0 only while disabled; once enabled it runs so
    // the first idle tick can launch the frame.
    if (state_q == S_IDLE && !ctrl_q[0]) presc_d = '0;
    else if (tick)                       presc_d = '0;
    else                                 presc_d = presc_q + PRESC_W'(1);

    if (tick) begin
      frame_el_d = sat_inc(frame_el_q);
      sync_el_d  = sat_inc(sync_el_q);
      case (state_q)
        S_IDLE: begin
          if (ctrl_q[0]) start_c = 1'b1;
        end
        S_PULSE: begin
          if (pulse_last) begin
            state_d = S_SPACE;
            slot_d  = '0;
            ppm_d   = 1'b1;
          end else begin
            slot_d = slot_q + 16'd1;
          end
        end
        S_SPACE: begin
          if (space_last) begin
            slot_d = '0;
            ppm_d  = 1'b0;
            if (chan_q == nch_sh_q) begin
              state_d   = S_SYNC_PULSE;
              sync_el_d = '0;
            end else begin
              state_d = S_PULSE;
              chan_d  = chan_q + 3'd1;
            end
          end else begin
            slot_d = slot_q + 16'd1;
          end
        end
        S_SYNC_PULSE: begin
          if (pulse_last) begin
            state_d = S_SYNC_SPACE;
            slot_d  = '0;
            ppm_d   = 1'b1;
          end else begin
            slot_d = slot_q + 16'd1;
          end
        end
        S_SYNC_SPACE: begin
          if (sync_done) begin
            if (ctrl_q[0]) start_c = 1'b1;
            else           state_d = S_IDLE;
          end
        end
        default: begin
          state_d = S_IDLE;
          ppm_d   = 1'b1;
        end
      endcase
    end

    if (start_c) begin
      for (int unsigned i = 0; i < 8; i++) ch_sh_d[i] = clamp_ch(ch_q[i]);
      nch_sh_d   = ctrl_q[3:1];
      frame_sh_d = frame_q;
      pw_sh_d    = clamp_pw(pw_q);
      state_d    = S_PULSE;
      chan_d     = '0;
      slot_d     = '0;
      frame_el_d = '0;
      sync_el_d  = '0;
      ppm_d      = 1'b0;
      fs_d       = 1'b1;
      fcnt_d     = fcnt_q + 15'd1;
    end
  end

  // State registers with asynchronous active-low reset
  always_ff @(posedge wb_clk_i or negedge wb_rst_i) begin
    if (!wb_rst_i) begin
      for (int unsigned i = 0; i < 8; i++) begin
        ch_q[i]    <= 16'd1500;
        ch_sh_q[i] <= 16'd1500;
      end
      ctrl_q     <= 4'hE;
      frame_q    <= 16'd22500;
      pw_q       <= 16'd300;
      nch_sh_q   <= 3'd7;
      frame_sh_q <= 16'd22500;
      pw_sh_q    <= 16'd300;
      state_q    <= S_IDLE;
      chan_q     <= '0;
      slot_q     <= '0;
      frame_el_q <= '0;
      sync_el_q  <= '0;
      presc_q    <= '0;
      fcnt_q     <= '0;
      ppm_q      <= 1'b1;
      fs_q       <= 1'b0;
    end else begin
      for (int unsigned i = 0; i < 8; i++) begin
        ch_q[i]    <= ch_d[i];
        ch_sh_q[i] <= ch_sh_d[i];
      end
      ctrl_q     <= ctrl_d;
      frame_q    <= frame_d;
      pw_q       <= pw_d;
      nch_sh_q   <= nch_sh_d;
      frame_sh_q <= frame_sh_d;
      pw_sh_q    <= pw_sh_d;
      state_q    <= state_d;
      chan_q     <= chan_d;
      slot_q     <= slot_d;
      frame_el_q <= frame_el_d;
      sync_el_q  <= sync_el_d;
      presc_q    <= presc_d;
      fcnt_q     <= fcnt_d;
      ppm_q      <= ppm_d;
      fs_q       <= fs_d;
    end
  end

endmodule
